// File: rtl/matmul_mem.sv
// matmul_mem: single-port word memory behind the matrix-multiply engine.
// The engine port has absolute priority; a host port borrows idle cycles.
// Reads travel through an RD_LAT-deep pipeline tagged with their owner, so
// each response is steered back to the port that issued it, in issue order.
module matmul_mem #(
  parameter int MEM_AW = 16,
  parameter int MEM_DW = 32,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_write,
  input  logic [MEM_AW-1:0] mem_addr,
  input  logic [MEM_DW-1:0] mem_wdata,
  output logic              mem_rdata_vld,
  output logic [MEM_DW-1:0] mem_rdata,
  input  logic              host_req,
  input  logic              host_write,
  input  logic [MEM_AW-1:0] host_addr,
  input  logic [MEM_DW-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rdata_vld,
  output logic [MEM_DW-1:0] host_rdata,
  output logic              err_oob
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Pipeline registers ahead of the output stage; the output registers are the last stage.
  localparam int NP = (RD_LAT > 1) ? RD_LAT - 1 : 1;

  logic [MEM_DW-1:0] mem_array [DEPTH];

  logic              eng_acc_s;
  logic              host_acc_s;
  logic              acc_s;
  logic              rd_acc_s;
  logic              wr_s;
  logic              oob_s;
  logic [MEM_AW-1:0] addr_s;
  logic [MEM_DW-1:0] wdata_s;
  logic [MEM_DW-1:0] rd_word_s;
  logic [IW-1:0]     idx_s;

  logic [NP-1:0]     pipe_vld_r;
  logic [NP-1:0]     pipe_own_r;
  logic [MEM_DW-1:0] pipe_data_r [NP];

  logic              fin_vld_s;
  logic              fin_own_s;
  logic [MEM_DW-1:0] fin_data_s;

  // Arbitration and access-port mux: engine wins, nothing is accepted during reset.
  always_comb begin
    eng_acc_s  = mem_req & ~rst;
    host_acc_s = host_req & ~mem_req & ~rst;
    acc_s      = eng_acc_s | host_acc_s;
    if (eng_acc_s) begin
      wr_s    = mem_write;
      addr_s  = mem_addr;
      wdata_s = mem_wdata;
    end else begin
      wr_s    = host_write;
      addr_s  = host_addr;
      wdata_s = host_wdata;
    end
    rd_acc_s = acc_s & ~wr_s;
    // Compare one bit wider so DEPTH == 2**MEM_AW is representable.
    oob_s    = ({1'b0, addr_s} >= (MEM_AW + 1)'(DEPTH));
    idx_s    = addr_s[IW-1:0];
    if (oob_s) begin
      rd_word_s = '0;
    end else begin
      rd_word_s = mem_array[idx_s];
    end
  end

  assign host_gnt = host_acc_s;

  // Array write: in-range accepted writes only; contents survive reset.
  always_ff @(posedge clk) begin
    if (acc_s & wr_s & ~oob_s) begin
      mem_array[idx_s] <= wdata_s;
    end
  end

  // Read latency pipeline: stage 1 registers the array word, later stages just shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld_r <= '0;
      pipe_own_r <= '0;
    end else begin
      pipe_vld_r[0]  <= rd_acc_s;
      pipe_own_r[0]  <= host_acc_s;
      pipe_data_r[0] <= rd_word_s;
      for (int i = 1; i < NP; i++) begin
        pipe_vld_r[i]  <= pipe_vld_r[i-1];
        pipe_own_r[i]  <= pipe_own_r[i-1];
        pipe_data_r[i] <= pipe_data_r[i-1];
      end
    end
  end

  // Select what feeds the output stage; with RD_LAT==1 the output stage is stage 1.
  always_comb begin
    if (RD_LAT == 1) begin
      fin_vld_s  = rd_acc_s;
      fin_own_s  = host_acc_s;
      fin_data_s = rd_word_s;
    end else begin
      fin_vld_s  = pipe_vld_r[NP-1];
      fin_own_s  = pipe_own_r[NP-1];
      fin_data_s = pipe_data_r[NP-1];
    end
  end

  // Output stage: steer the pulse by owner, each data bus holds its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rdata_vld  <= 1'b0;
      host_rdata_vld <= 1'b0;
      mem_rdata      <= '0;
      host_rdata     <= '0;
    end else begin
      mem_rdata_vld  <= fin_vld_s & ~fin_own_s;
      host_rdata_vld <= fin_vld_s & fin_own_s;
      if (fin_vld_s & ~fin_own_s) begin
        mem_rdata <= fin_data_s;
      end
      if (fin_vld_s & fin_own_s) begin
        host_rdata <= fin_data_s;
      end
    end
  end

  // Sticky out-of-range flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_oob <= 1'b0;
    end else if (acc_s & oob_s) begin
      err_oob <= 1'b1;
    end
  end

endmodule

// File: tb/tb_matmul_mem.sv
// Directed bench for matmul_mem: three instances (RD_LAT 2, 1, 4) share
// stimulus; the RD_LAT=2 instance is checked fully, the others on pulse timing.
module tb_matmul_mem;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        host_req;
  logic        host_write;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;

  logic        d2_mvld, d2_hvld, d2_gnt, d2_err;
  logic [31:0] d2_mdata, d2_hdata;
  logic        d1_mvld, d1_hvld, d1_gnt, d1_err;
  logic [31:0] d1_mdata, d1_hdata;
  logic        d4_mvld, d4_hvld, d4_gnt, d4_err;
  logic [31:0] d4_mdata, d4_hdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        mreq;
    logic        mwr;
    logic [15:0] maddr;
    logic [31:0] mwdata;
    logic        hreq;
    logic        hwr;
    logic [15:0] haddr;
    logic [31:0] hwdata;
    logic        gnt;
    logic        mvld;
    logic [31:0] mdata;
    logic        hvld;
    logic [31:0] hdata;
    logic        err;
    logic        v1;
    logic        v4;
  } vec_t;

  vec_t tbl[$];

  matmul_mem #(.MEM_AW(16), .MEM_DW(32), .DEPTH(1024), .RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata_vld(d2_mvld), .mem_rdata(d2_mdata),
    .host_req(host_req), .host_write(host_write), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(d2_gnt), .host_rdata_vld(d2_hvld), .host_rdata(d2_hdata), .err_oob(d2_err)
  );

  matmul_mem #(.MEM_AW(16), .MEM_DW(32), .DEPTH(1024), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata_vld(d1_mvld), .mem_rdata(d1_mdata),
    .host_req(host_req), .host_write(host_write), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(d1_gnt), .host_rdata_vld(d1_hvld), .host_rdata(d1_hdata), .err_oob(d1_err)
  );

  matmul_mem #(.MEM_AW(16), .MEM_DW(32), .DEPTH(1024), .RD_LAT(4)) dut4 (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata_vld(d4_mvld), .mem_rdata(d4_mdata),
    .host_req(host_req), .host_write(host_write), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(d4_gnt), .host_rdata_vld(d4_hvld), .host_rdata(d4_hdata), .err_oob(d4_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic mreq, input logic mwr, input logic [15:0] maddr, input logic [31:0] mwd,
                     input logic hreq, input logic hwr, input logic [15:0] haddr, input logic [31:0] hwd,
                     input logic gnt, input logic mvld, input logic [31:0] mdata,
                     input logic hvld, input logic [31:0] hdata, input logic err,
                     input logic v1, input logic v4);
    vec_t v;
    v.mreq = mreq; v.mwr = mwr; v.maddr = maddr; v.mwdata = mwd;
    v.hreq = hreq; v.hwr = hwr; v.haddr = haddr; v.hwdata = hwd;
    v.gnt = gnt; v.mvld = mvld; v.mdata = mdata; v.hvld = hvld; v.hdata = hdata;
    v.err = err; v.v1 = v1; v.v4 = v4;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic mreq, input logic mwr, input logic [15:0] maddr, input logic [31:0] mwd,
                       input logic hreq, input logic hwr, input logic [15:0] haddr, input logic [31:0] hwd);
    mem_req = mreq; mem_write = mwr; mem_addr = maddr; mem_wdata = mwd;
    host_req = hreq; host_write = hwr; host_addr = haddr; host_wdata = hwd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Each row: inputs for cycle t, expected outputs observed during cycle t.
    //   mreq  mwr   maddr    mwdata          hreq  hwr   haddr      hwdata        gnt   mvld  mdata           hvld  hdata         err   v1    v4
    // host loads 0x11/0x22/0x33, engine reads 0..2 back-to-back
    add(1'b0, 1'b0, 16'd0, 32'h0,        1'b1, 1'b1, 16'd0,    32'h11,  1'b1, 1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 1'b0, 1'b0); // 0
    add(1'b0, 1'b0, 16'd0, 32'h0,        1'b1, 1'b1, 16'd1,    32'h22,  1'b1, 1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 1'b0, 1'b0); // 1
    add(1'b0, 1'b0, 16'd0, 32'h0,        1'b1, 1'b1, 16'd2,    32'h33,  1'b1, 1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 1'b0, 1'b0); // 2
    add(1'b1, 1'b0, 16'd0, 32'h0,        1'b0, 1'b0, 16'd0,    32'h0,   1'b0, 1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 1'b0, 1'b0); // 3
    add(1'b1, 1'b0, 16'd1, 32'h0,        1'b0, 1'b0, 16'd0,    32'h0,   1'b0, 1'b0, 32'h0,        1'b0, 32'h0,  1'b0, 1'b1, 1'b0); // 4
    add(1'b1, 1'b0, 16'd2, 32'h0,        1'b0, 1'b0, 16'd0,    32'h0,   1'b0, 1'b1, 32'h11,       1'b0, 32'h0,  1'b0, 1'b1, 1'b0); // 5
    add(1'b0, 1'b0, 16'd0, 32'h0,        1'b1, 1'b1, 16'd5,    32'h55,  1'b1, 1'b1, 32'h22,       1'b0, 32'h0,  1'b0, 1'b1, 1'b0); // 6
    add(1'b0, 1'b0, 16'd0, 32'h0,        1'b0, 1'b0, 16'd0,    32'h0,   1'b0, 1'b1, 32'h33,       1'b0, 32'h0,  1'b0, 1'b0, 1'b1); // 7
    add(1'b0, 1'b0, 16'd0, 32'h0,        1'b0, 1'b0, 16'd0,    32'h0,   1'b0, 1'b0, 32'h33,       1'b0, 32'h0,  1'b0, 1'b0, 1'b1); // 8
    add(1'b0, 1'b0, 16'd0, 32'h0,        1'b0, 1'b0, 16'd0,    32'h0,   1'b0, 1'b0, 32'h33,       1'b0, 32'h0,  1'b0, 1'b0, 1'b1); // 9
    // engine streams 4 reads while host read of addr 5 waits
    add(1'b1, 1'b0, 16'd0, 32'h0,        1'b1, 1'b0, 16'd5,    32'h0,   1'b0, 1'b0, 32'h33,       1'b0, 32'h0,  1'b0, 1'b0, 1'b0); // 10
    add(1'b1, 1'b0, 16'd1, 32'h0,        1'b1, 1'b0, 16'd5,    32'h0,   1'b0, 1'b0, 32'h33,       1'b0, 32'h0,  1'b0, 1'b1, 1'b0); // 11
    add(1'b1, 1'b0, 16'd2, 32'h0,        1'b1, 1'b0, 16'd5,    32'h0,   1'b0, 1'b1, 32'h11,       1'b0, 32'h0,  1'b0, 1'b1, 1'b0); // 12
    add(1'b1, 1'b0, 16'd0, 32'h0,        1'b1, 1'b0, 16'd5,    32'h0,   1'b0, 1'b1, 32'h22,       1'b0, 32'h0,  1'b0, 1'b1, 1'b0); // 13
    add(1'b0, 1'b0, 16'd0, 32'h0,        1'b1, 1'b0, 16'd5,    32'h0,   1'b1, 1'b1, 32'h33,       1'b0, 32'h0,  1'b0, 1'b1, 1'b1); // 14
    add(1'b0, 1'b0, 16'd0, 32'h0,        1'b0, 1'b0, 16'd0,    32'h0,   1'b0, 1'b1, 32'h11,       1'b0, 32'h0,  1'b0, 1'b0, 1'b1); // 15
    add(1'b0, 1'b0, 16'd0, 32'h0,        1'b0, 1'b0, 16'd0,    32'h0,   1'b0, 1'b0, 32'h11,       1'b1, 32'h55, 1'b0, 1'b0, 1'b1); // 16
    // read-after-write on addr 7
    add(1'b1, 1'b1, 16'd7, 32'hDEADBEEF, 1'b0, 1'b0, 16'd0,    32'h0,   1'b0, 1'b0, 32'h11,       1'b0, 32'h55, 1'b0, 1'b0, 1'b1); // 17
    add(1'b1, 1'b0, 16'd7, 32'h0,        1'b0, 1'b0, 16'd0,    32'h0,   1'b0, 1'b0, 32'h11,       1'b0, 32'h55, 1'b0, 1'b0, 1'b0); // 18
    add(1'b0, 1'b0, 16'd0, 32'h0,        1'b0, 1'b0, 16'd0,    32'h0,   1'b0, 1'b0, 32'h11,       1'b0, 32'h55, 1'b0, 1'b1, 1'b0); // 19
    add(1'b0, 1'b0, 16'd0, 32'h0,        1'b0, 1'b0, 16'd0,    32'h0,   1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h55, 1'b0, 1'b0, 1'b0); // 20
    add(1'b0, 1'b0, 16'd0, 32'h0,        1'b0, 1'b0, 16'd0,    32'h0,   1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h55, 1'b0, 1'b0, 1'b0); // 21
    add(1'b0, 1'b0, 16'd0, 32'h0,        1'b0, 1'b0, 16'd0,    32'h0,   1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h55, 1'b0, 1'b0, 1'b1); // 22
    // out of range: write 1024 dropped (would alias addr 0), read 1024 returns 0
    add(1'b0, 1'b0, 16'd0, 32'h0,        1'b1, 1'b1, 16'd1024, 32'hBAD, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 32'h55, 1'b0, 1'b0, 1'b0); // 23
    add(1'b0, 1'b0, 16'd0, 32'h0,        1'b1, 1'b0, 16'd1024, 32'h0,   1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 32'h55, 1'b1, 1'b0, 1'b0); // 24
    add(1'b1, 1'b0, 16'd0, 32'h0,        1'b0, 1'b0, 16'd0,    32'h0,   1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h55, 1'b1, 1'b0, 1'b0); // 25
    add(1'b0, 1'b0, 16'd0, 32'h0,        1'b0, 1'b0, 16'd0,    32'h0,   1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 32'h0,  1'b1, 1'b1, 1'b0); // 26
    add(1'b0, 1'b0, 16'd0, 32'h0,        1'b0, 1'b0, 16'd0,    32'h0,   1'b0, 1'b1, 32'h11,       1'b0, 32'h0,  1'b1, 1'b0, 1'b0); // 27
    add(1'b0, 1'b0, 16'd0, 32'h0,        1'b0, 1'b0, 16'd0,    32'h0,   1'b0, 1'b0, 32'h11,       1'b0, 32'h0,  1'b1, 1'b0, 1'b0); // 28
    add(1'b0, 1'b0, 16'd0, 32'h0,        1'b0, 1'b0, 16'd0,    32'h0,   1'b0, 1'b0, 32'h11,       1'b0, 32'h0,  1'b1, 1'b0, 1'b1); // 29

    // Reset with a host request pending: nothing granted, outputs cleared.
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'd0, 32'h0, 1'b1, 1'b1, 16'd3, 32'hABCD);
    repeat (3) @(posedge clk);
    #1;
    chk("reset gnt", {31'd0, d2_gnt}, 32'd0);
    chk("reset mvld", {31'd0, d2_mvld}, 32'd0);
    chk("reset hvld", {31'd0, d2_hvld}, 32'd0);
    chk("reset mdata", d2_mdata, 32'h0);
    chk("reset hdata", d2_hdata, 32'h0);
    chk("reset err", {31'd0, d2_err}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].mreq, tbl[i].mwr, tbl[i].maddr, tbl[i].mwdata,
            tbl[i].hreq, tbl[i].hwr, tbl[i].haddr, tbl[i].hwdata);
      #1;
      chk($sformatf("row%0d gnt", i),   {31'd0, d2_gnt},  {31'd0, tbl[i].gnt});
      chk($sformatf("row%0d mvld", i),  {31'd0, d2_mvld}, {31'd0, tbl[i].mvld});
      chk($sformatf("row%0d mdata", i), d2_mdata,         tbl[i].mdata);
      chk($sformatf("row%0d hvld", i),  {31'd0, d2_hvld}, {31'd0, tbl[i].hvld});
      chk($sformatf("row%0d hdata", i), d2_hdata,         tbl[i].hdata);
      chk($sformatf("row%0d err", i),   {31'd0, d2_err},  {31'd0, tbl[i].err});
      chk($sformatf("row%0d lat1 vld", i), {31'd0, d1_mvld}, {31'd0, tbl[i].v1});
      chk($sformatf("row%0d lat4 vld", i), {31'd0, d4_mvld}, {31'd0, tbl[i].v4});
      @(posedge clk);
      #1;
    end

    // Reset mid-flight: engine read in flight, then a 1-cycle reset with a host write presented.
    drive(1'b1, 1'b0, 16'd0, 32'h0, 1'b0, 1'b0, 16'd0, 32'h0);
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'd0, 32'h0, 1'b1, 1'b1, 16'd0, 32'hBAD0);
    #1;
    chk("midrst gnt", {31'd0, d2_gnt}, 32'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 16'd0, 32'h0, 1'b0, 1'b0, 16'd0, 32'h0);
    #1;
    chk("postrst mdata", d2_mdata, 32'h0);
    chk("postrst hdata", d2_hdata, 32'h0);
    chk("postrst hvld", {31'd0, d2_hvld}, 32'd0);
    chk("postrst err", {31'd0, d2_err}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("postrst%0d mvld", k), {31'd0, d2_mvld}, 32'd0);
      chk($sformatf("postrst%0d lat4 vld", k), {31'd0, d4_mvld}, 32'd0);
      tick();
    end
    // Data written before reset is still there; the write during reset was ignored.
    drive(1'b1, 1'b0, 16'd2, 32'h0, 1'b0, 1'b0, 16'd0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 16'd0, 32'h0, 1'b1, 1'b0, 16'd0, 32'h0);
    #1;
    chk("postrst host gnt", {31'd0, d2_gnt}, 32'd1);
    tick();
    drive(1'b0, 1'b0, 16'd0, 32'h0, 1'b0, 1'b0, 16'd0, 32'h0);
    #1;
    chk("postrst eng vld", {31'd0, d2_mvld}, 32'd1);
    chk("postrst eng data", d2_mdata, 32'h33);
    tick();
    chk("postrst host vld", {31'd0, d2_hvld}, 32'd1);
    chk("postrst host data", d2_hdata, 32'h11);
    chk("postrst host no eng", {31'd0, d2_mvld}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
